// File: rtl/jtdd_pkg.sv
// Shared types for the main<->sub CPU com-RAM handshake.
package jtdd_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTING = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } share_st_e;

  localparam logic [7:0] FF_DATA = 8'hFF;

endpackage

// File: rtl/jtdd_sub_share_if.sv
// Main/sub CPU bus bundle around the shared com RAM; slave is the share block.
interface jtdd_sub_share_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  logic          halt_req;
  logic          sub_busy;
  logic          sub_halt_n;
  logic          mcu_ba;
  logic          main_cs;
  logic          main_we;
  logic [AW-1:0] main_AB;
  logic [DW-1:0] main_dout;
  logic [DW-1:0] main_din;
  logic          sub_cs;
  logic          sub_we;
  logic [AW-1:0] sub_AB;
  logic [DW-1:0] sub_dout;
  logic [DW-1:0] sub_din;
  logic          nmi_set;
  logic          nmi_clr;
  logic          sub_nmi_n;
  logic          irq_set;
  logic          main_irq2;

  modport master (
    output halt_req, sub_busy, main_cs, main_we, main_AB, main_dout,
           sub_cs, sub_we, sub_AB, sub_dout, nmi_set, nmi_clr, irq_set,
    input  sub_halt_n, mcu_ba, main_din, sub_din, sub_nmi_n, main_irq2
  );

  modport slave (
    input  halt_req, sub_busy, main_cs, main_we, main_AB, main_dout,
           sub_cs, sub_we, sub_AB, sub_dout, nmi_set, nmi_clr, irq_set,
    output sub_halt_n, mcu_ba, main_din, sub_din, sub_nmi_n, main_irq2
  );
endinterface

// File: rtl/jtframe_ram.sv
// Single-port synchronous RAM, registered read (read-before-write).
module jtframe_ram #(
  parameter int aw = 9,
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic [aw-1:0] addr,
  input  logic [dw-1:0] data,
  input  logic          we,
  output logic [dw-1:0] q
);

  logic [dw-1:0] r_mem [0:(2**aw)-1];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= data;
    q <= r_mem[addr];
  end

endmodule

// File: rtl/jtdd_sub_share.sv
// Sub-CPU side of the shared com RAM: halt/grant handshake, owner-muxed RAM,
// main->sub NMI flag and sub->main irq2 stretcher.
module jtdd_sub_share
  import jtdd_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 nRESET,
  input  logic                 cen_sub,
  jtdd_sub_share_if.slave      bus
);

  share_st_e     r_st, w_nx;
  logic          w_halt_n, w_ba;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data, w_q;
  logic          w_we;
  logic          r_q_vld;
  logic          r_nmi;
  logic          r_irq;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET)      r_st <= RUN;
    else if (cen_sub) r_st <= w_nx;
  end

  // An aborted request wins over a grant in the same cycle.
  always_comb begin
    w_nx = r_st;
    case (r_st)
      RUN:     if (bus.halt_req) w_nx = HALTING;
      HALTING: begin
        if (!bus.halt_req)     w_nx = RUN;
        else if (!bus.sub_busy) w_nx = GRANT;
      end
      GRANT:   if (!bus.halt_req) w_nx = RELEASE;
      RELEASE: w_nx = RUN;
      default: w_nx = RUN;
    endcase
  end

  always_comb begin
    w_halt_n = 1'b1;
    w_ba     = 1'b0;
    case (r_st)
      HALTING: w_halt_n = 1'b0;
      GRANT:   begin w_halt_n = 1'b0; w_ba = 1'b1; end
      RELEASE: w_halt_n = 1'b0;
      default: ;
    endcase
  end

  assign w_addr = w_ba ? bus.main_AB   : bus.sub_AB;
  assign w_data = w_ba ? bus.main_dout : bus.sub_dout;
  assign w_we   = w_ba ? (bus.main_cs & bus.main_we) : (bus.sub_cs & bus.sub_we);

  jtframe_ram #(.aw(AW), .dw(DW)) u_ram (
    .clk  (clk),
    .addr (w_addr),
    .data (w_data),
    .we   (w_we),
    .q    (w_q)
  );

  // RAM output is not reset, so read data is masked until one clk after reset.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) r_q_vld <= 1'b0;
    else         r_q_vld <= 1'b1;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET)          r_nmi <= 1'b0;
    else if (bus.nmi_set) r_nmi <= 1'b1;
    else if (bus.nmi_clr) r_nmi <= 1'b0;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET)          r_irq <= 1'b0;
    else if (bus.irq_set) r_irq <= 1'b1;
    else if (cen_sub)     r_irq <= 1'b0;
  end

  assign bus.sub_halt_n = w_halt_n;
  assign bus.mcu_ba     = w_ba;
  assign bus.main_din   = ( w_ba && r_q_vld) ? w_q : DW'(FF_DATA);
  assign bus.sub_din    = (!w_ba && r_q_vld) ? w_q : DW'(FF_DATA);
  assign bus.sub_nmi_n  = ~r_nmi;
  assign bus.main_irq2  = r_irq;

endmodule
